// File: rtl/align_input_buffer.sv
// Assembles WORD_WIDTH-wide stream words into a DATA_WIDTH buffer for the alignment network.
// Optional flush of a partly filled buffer is enabled by defining ALIGN_INPUT_BUFFER_FLUSH_EN.
module align_input_buffer #(
   parameter  int DATA_WIDTH = 8,
   parameter  int WORD_WIDTH = 1,
   localparam int NWORDS     = DATA_WIDTH / WORD_WIDTH,
   localparam int AW         = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [WORD_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  cfg_reverse,
   input  logic [AW-1:0]         cfg_align_start,
   output logic [DATA_WIDTH-1:0] out_buf,
   output logic                  out_reverse,
   output logic [AW-1:0]         out_align_start,
   output logic                  out_valid,
   input  logic                  out_ready,
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
   input  logic                  flush,
   output logic                  out_partial,
`endif
   output logic                  dbg_state
);

   // Handshake: a word moves when in_valid && in_ready, a buffer moves when
   // out_valid && out_ready; neither side may make valid depend on ready.
   localparam logic [0:0] FILL = 1'b0;
   localparam logic [0:0] FULL = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [DATA_WIDTH-1:0] buf_q, buf_d;
   logic                  rev_q, rev_d;
   logic [AW-1:0]         align_q, align_d;
   logic                  run_q;
   logic                  accept;
   logic                  consume;
   logic                  last_word;
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
   logic                  partial_q, partial_d;
   int                    fill_cnt;
`endif

   assign out_valid       = (state_q == FULL);
   // run_q keeps in_ready low during reset and raises it at the first edge after release.
   assign in_ready        = run_q & ((state_q == FILL) | out_ready);
   assign accept          = in_valid & in_ready;
   assign consume         = out_valid & out_ready;
   assign last_word       = (wr_ptr_q == AW'(NWORDS - 1));
   assign out_buf         = buf_q;
   assign out_reverse     = rev_q;
   assign out_align_start = align_q;
   assign dbg_state       = state_q[0];
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
   assign out_partial     = partial_q;
`endif

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      buf_d    = buf_q;
      rev_d    = rev_q;
      align_d  = align_q;
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
      partial_d = partial_q;
      fill_cnt  = 0;
      if (consume) partial_d = 1'b0;
`endif
      // In FULL an accept only happens together with a consume, and wr_ptr is 0 there,
      // so the same path restarts the next buffer with no bubble.
      if (accept) begin
         for (int k = 0; k < NWORDS; k++) begin
            if (wr_ptr_q == AW'(k)) buf_d[k*WORD_WIDTH +: WORD_WIDTH] = in_data;
         end
         if (wr_ptr_q == '0) begin
            rev_d   = cfg_reverse;
            align_d = cfg_align_start;
         end
         if (last_word) begin
            wr_ptr_d = '0;
            state_d  = FULL;
         end else begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            state_d  = FILL;
         end
      end else if (consume) begin
         wr_ptr_d = '0;
         state_d  = FILL;
      end
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
      if (flush && (state_q == FILL) && (wr_ptr_q != '0) && !(accept && last_word)) begin
         fill_cnt = accept ? int'(wr_ptr_q) + 1 : int'(wr_ptr_q);
         for (int k = 0; k < NWORDS; k++) begin
            if (k >= fill_cnt) buf_d[k*WORD_WIDTH +: WORD_WIDTH] = '0;
         end
         wr_ptr_d  = '0;
         state_d   = FULL;
         partial_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FILL;
         wr_ptr_q <= '0;
         buf_q    <= '0;
         rev_q    <= 1'b0;
         align_q  <= '0;
         run_q    <= 1'b0;
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
         partial_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         buf_q    <= buf_d;
         rev_q    <= rev_d;
         align_q  <= align_d;
         run_q    <= 1'b1;
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
         partial_q <= partial_d;
`endif
      end
   end

endmodule

// File: tb/tb_align_input_buffer.sv
// Bench for align_input_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_align_input_buffer;

   localparam int DW = 8;
   localparam int WW = 1;
   localparam int NW = DW / WW;
   localparam int AW = 3;
   localparam int EW = DW + AW + 2;   // {partial, align, reverse, buf}

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [WW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          cfg_reverse = 1'b0;
   logic [AW-1:0] cfg_align_start = '0;
   logic [DW-1:0] out_buf;
   logic          out_reverse;
   logic [AW-1:0] out_align_start;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          dbg_state;
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
   logic          flush = 1'b0;
   logic          out_partial;
`endif

   align_input_buffer #(.DATA_WIDTH(DW), .WORD_WIDTH(WW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_data         (in_data),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .cfg_reverse     (cfg_reverse),
      .cfg_align_start (cfg_align_start),
      .out_buf         (out_buf),
      .out_reverse     (out_reverse),
      .out_align_start (out_align_start),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
      .flush           (flush),
      .out_partial     (out_partial),
`endif
      .dbg_state       (dbg_state)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] con_log[$];
   logic [WW-1:0] cur_q[$];
   logic          cur_rev;
   logic [AW-1:0] cur_al;
   logic [EW-1:0] last_con;
   int            n_con;
   bit            saw_not_ready;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [EW-1:0] pack_entry(input logic part);
      logic [DW-1:0] b;
      b = '0;
      for (int k = 0; k < cur_q.size(); k++) b[k*WW +: WW] = cur_q[k];
      return {part, cur_al, cur_rev, b};
   endfunction

   // One clock: drive after the falling edge, sample 1ns later, then advance the model.
   task automatic cycle(input logic v, input logic [WW-1:0] d, input logic rdy,
                        input logic rev, input logic [AW-1:0] al);
      logic          exp_ready;
      logic [EW-1:0] front;
      @(negedge clk);
      in_valid = v; in_data = d; out_ready = rdy; cfg_reverse = rev; cfg_align_start = al;
      #1;
      exp_ready = (exp_q.size() == 0) || rdy;
      check("out_valid", out_valid, exp_q.size() != 0);
      check("in_ready", in_ready, exp_ready);
      if (in_ready !== 1'b1) saw_not_ready = 1'b1;
      if (exp_q.size() != 0) begin
         front = exp_q[0];
         check("out_buf", out_buf, front[DW-1:0]);
         check("out_reverse", out_reverse, front[DW]);
         check("out_align_start", out_align_start, front[DW+AW:DW+1]);
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
         check("out_partial", out_partial, front[EW-1]);
`endif
      end
`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
      else check("out_partial_idle", out_partial, 1'b0);
`endif
      if ((exp_q.size() != 0) && rdy) begin
         last_con = exp_q.pop_front();
         con_log.push_back(last_con);
         n_con++;
      end
      if (v && exp_ready) begin
         if (cur_q.size() == 0) begin
            cur_rev = rev;
            cur_al  = al;
         end
         cur_q.push_back(d);
         if (cur_q.size() == NW) begin
            exp_q.push_back(pack_entry(1'b0));
            cur_q.delete();
         end
      end
   endtask

   task automatic feed_byte(input logic [7:0] b, input logic rdy, input logic rev,
                            input logic [AW-1:0] al);
      for (int i = 0; i < 8; i++) cycle(1'b1, b[i], rdy, rev, al);
   endtask

   task automatic apply_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_in_ready", in_ready, 1'b0);
      check("rst_out_buf", out_buf, '0);
      check("rst_out_reverse", out_reverse, 1'b0);
      check("rst_out_align_start", out_align_start, '0);
      exp_q.delete();
      cur_q.delete();
      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] bits;
      apply_reset();

      // 0x12 LSB first, then a 5-cycle stall and a consume
      feed_byte(8'h12, 1'b0, 1'b0, 3'd3);
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b0, '0);
      n_con = 0;
      cycle(1'b0, '0, 1'b1, 1'b0, '0);
      check("d1_consumes", n_con, 1);
      check("d1_buf", last_con[DW-1:0], 8'h12);
      check("d1_align", last_con[DW+AW:DW+1], 3'd3);
      check("d1_rev", last_con[DW], 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, '0);

      // back-to-back buffers with no bubble
      n_con = 0; saw_not_ready = 1'b0; con_log.delete();
      feed_byte(8'h12, 1'b1, 1'b1, 3'd5);
      feed_byte(8'hA5, 1'b1, 1'b0, 3'd1);
      check("d2_ready_always", saw_not_ready, 1'b0);
      cycle(1'b0, '0, 1'b1, 1'b0, '0);
      check("d2_consumes", n_con, 2);
      if (con_log.size() == 2) begin
         check("d2_buf0", con_log[0][DW-1:0], 8'h12);
         check("d2_buf1", con_log[1][DW-1:0], 8'hA5);
      end

      // cfg change mid-fill only affects the next buffer
      bits = 8'h6C;
      for (int i = 0; i < 8; i++) cycle(1'b1, bits[i], 1'b0, 1'b0, (i < 4) ? 3'd2 : 3'd6);
      cycle(1'b0, '0, 1'b1, 1'b0, 3'd6);
      check("d3_align_first", last_con[DW+AW:DW+1], 3'd2);
      feed_byte(8'h3C, 1'b0, 1'b1, 3'd6);
      cycle(1'b0, '0, 1'b1, 1'b0, 3'd6);
      check("d3_align_next", last_con[DW+AW:DW+1], 3'd6);
      check("d3_rev_next", last_con[DW], 1'b1);

      // reset mid-fill discards the partial buffer
      bits = 8'h15;
      for (int i = 0; i < 5; i++) cycle(1'b1, bits[i], 1'b1, 1'b1, 3'd4);
      apply_reset();
      n_con = 0;
      feed_byte(8'hFF, 1'b0, 1'b0, 3'd0);
      cycle(1'b0, '0, 1'b1, 1'b0, '0);
      check("d4_consumes", n_con, 1);
      check("d4_buf", last_con[DW-1:0], 8'hFF);

      // random traffic
      for (int i = 0; i < 800; i++)
         cycle($urandom_range(0, 3) != 0, WW'($urandom), $urandom_range(0, 2) != 0,
               1'($urandom), AW'($urandom_range(0, 7)));
      cycle(1'b0, '0, 1'b1, 1'b0, '0);
      cycle(1'b0, '0, 1'b1, 1'b0, '0);

`ifdef ALIGN_INPUT_BUFFER_FLUSH_EN
      // flush after three words yields a zero-padded partial buffer
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 3'd1);
      cycle(1'b1, 1'b1, 1'b0, 1'b1, 3'd1);
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
      #1;
      check("f_in_ready", in_ready, 1'b1);
      @(negedge clk);
      flush = 1'b0;
      exp_q.push_back(pack_entry(1'b1));
      cur_q.delete();
      cycle(1'b0, '0, 1'b1, 1'b0, '0);
      check("f_buf", last_con[DW-1:0], 8'h05);
      cycle(1'b0, '0, 1'b0, 1'b0, '0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
